// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL types and helpers for the data-memory link devices.
package tl_ul_pkg;

  localparam int TL_DW = 32;
  localparam int TL_MW = TL_DW / 8;

  // Channel A opcodes understood by UL devices
  typedef enum logic [2:0] {
    PUT_FULL    = 3'd0,
    PUT_PARTIAL = 3'd1,
    GET         = 3'd4
  } tl_a_op_e;

  // Channel D response opcodes
  typedef enum logic [2:0] {
    ACK      = 3'd0,
    ACK_DATA = 3'd1
  } tl_d_op_e;

  // Channel A payload as seen by the device; opcode kept raw so illegal values survive
  typedef struct packed {
    logic [2:0]       opcode;
    logic [1:0]       size;
    logic [TL_MW-1:0] mask;
    logic [TL_DW-1:0] data;
  } tl_a_req_t;

  // Channel D payload held in the response buffer
  typedef struct packed {
    tl_d_op_e         opcode;
    logic [1:0]       size;
    logic [TL_DW-1:0] data;
    logic             error;
  } tl_d_rsp_t;

  // Byte lanes a request of the given size may touch at the given word offset
  function automatic logic [TL_MW-1:0] lane_window(input logic [1:0] size,
                                                   input logic [1:0] offset);
    logic [TL_MW-1:0] win;
    case (size)
      2'd0:    win = 4'b0001 << offset;
      2'd1:    win = offset[1] ? 4'b1100 : 4'b0011;
      2'd2:    win = 4'b1111;
      default: win = 4'b0000;
    endcase
    return win;
  endfunction

  // Spread a per-byte lane mask over a full data word
  function automatic logic [TL_DW-1:0] lane_expand(input logic [TL_MW-1:0] lanes);
    return {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
  endfunction

endpackage

// File: rtl/tl_ul_req_check.sv
// Combinational legality check for a TL-UL channel A request.
module tl_ul_req_check
  import tl_ul_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 12
) (
  input  logic [2:0]        opcode_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic [1:0]        size_i,
  input  logic [3:0]        mask_i,
  output logic              err_o,
  output logic [3:0]        window_o
);

  logic        op_illegal;
  logic        size_illegal;
  logic        misaligned;
  logic [31:0] idx_ext;
  logic        out_of_range;
  logic        lanes_outside;
  logic        full_mismatch;
  logic        get_empty;

  // Any single violation rejects the request
  always_comb begin
    window_o      = lane_window(size_i, address_i[1:0]);
    op_illegal    = !((opcode_i == PUT_FULL) || (opcode_i == PUT_PARTIAL) || (opcode_i == GET));
    size_illegal  = (size_i == 2'd3);
    misaligned    = ((size_i == 2'd1) && address_i[0]) ||
                    ((size_i == 2'd2) && (address_i[1:0] != 2'b00));
    idx_ext       = 32'(address_i[ADDR_W-1:2]);
    out_of_range  = (idx_ext >= 32'(DEPTH));
    lanes_outside = |(mask_i & ~window_o);
    full_mismatch = (opcode_i == PUT_FULL) && (mask_i != window_o);
    get_empty     = (opcode_i == GET) && (mask_i == 4'b0000);
    err_o         = op_illegal | size_illegal | misaligned | out_of_range |
                    lanes_outside | full_mismatch | get_empty;
  end

endmodule

// File: rtl/tl_ul_dmem_device.sv
// TL-UL device end of the data-memory link: word memory plus one-entry response buffer.
module tl_ul_dmem_device
  import tl_ul_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [2:0]        a_opcode_i,
  input  logic [ADDR_W-1:0] a_address_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic [1:0]        a_size_i,
  input  logic [3:0]        a_mask_i,
  output logic              d_valid_o,
  input  logic              d_ready_i,
  output logic [2:0]        d_opcode_o,
  output logic [1:0]        d_size_o,
  output logic [DATA_W-1:0] d_data_o,
  output logic              d_error_o
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } state_e;

  state_e      state_q, state_d;
  tl_d_rsp_t   rsp_q, rsp_d;
  logic        d_valid_q, d_valid_d;

  tl_a_req_t   req;
  tl_d_rsp_t   new_rsp;
  logic        accept;
  logic        req_err;
  logic [3:0]  window;
  logic        is_get;
  logic        is_put;
  logic        wr_en;
  logic [IDX_W-1:0]  widx;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] mem [DEPTH];

  tl_ul_req_check #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_req_check (
    .opcode_i  (a_opcode_i),
    .address_i (a_address_i),
    .size_i    (a_size_i),
    .mask_i    (a_mask_i),
    .err_o     (req_err),
    .window_o  (window)
  );

  // Handshake and request decode; a_ready deliberately ignores a_valid
  always_comb begin
    req.opcode = a_opcode_i;
    req.size   = a_size_i;
    req.mask   = a_mask_i;
    req.data   = a_data_i;
    a_ready_o  = (state_q == ST_IDLE) || d_ready_i;
    accept     = a_valid_i && a_ready_o;
    is_get     = (req.opcode == GET);
    is_put     = (req.opcode == PUT_FULL) || (req.opcode == PUT_PARTIAL);
    wr_en      = accept && is_put && !req_err && !rst;
    widx       = a_address_i[2 +: IDX_W];
    rd_word    = mem[widx];
  end

  // Build the response that an accepted request will load into the buffer
  always_comb begin
    new_rsp        = '0;
    new_rsp.opcode = is_get ? ACK_DATA : ACK;
    new_rsp.size   = req.size;
    new_rsp.error  = req_err;
    new_rsp.data   = (is_get && !req_err) ? (rd_word & lane_expand(req.mask & window)) : '0;
  end

  // Next-state for the response buffer: load on accept, drain on d_ready, hold otherwise
  always_comb begin
    state_d   = state_q;
    rsp_d     = rsp_q;
    d_valid_d = d_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_RESP;
          rsp_d     = new_rsp;
          d_valid_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (d_ready_i) begin
          if (accept) begin
            rsp_d = new_rsp;
          end else begin
            state_d   = ST_IDLE;
            d_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        d_valid_d = 1'b0;
      end
    endcase
  end

  // Response FSM with registered channel D outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rsp_q     <= '0;
      d_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_q     <= rsp_d;
      d_valid_q <= d_valid_d;
    end
  end

  // Byte-enabled memory write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (req.mask[b]) begin
          mem[widx][8*b +: 8] <= req.data[8*b +: 8];
        end
      end
    end
  end

  // Channel D outputs come straight from the buffer
  always_comb begin
    d_valid_o  = d_valid_q;
    d_opcode_o = rsp_q.opcode;
    d_size_o   = rsp_q.size;
    d_data_o   = rsp_q.data;
    d_error_o  = rsp_q.error;
  end

endmodule

// File: tb/tb_tl_ul_dmem_device.sv
// Self-checking bench for tl_ul_dmem_device: vector table plus scoreboard queue.
module tb_tl_ul_dmem_device;

  logic        clk;
  logic        rst;
  logic        a_valid_i;
  logic        a_ready_o;
  logic [2:0]  a_opcode_i;
  logic [11:0] a_address_i;
  logic [31:0] a_data_i;
  logic [1:0]  a_size_i;
  logic [3:0]  a_mask_i;
  logic        d_valid_o;
  logic        d_ready_i;
  logic [2:0]  d_opcode_o;
  logic [1:0]  d_size_o;
  logic [31:0] d_data_o;
  logic        d_error_o;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [11:0] addr;
    logic [1:0]  size;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        eerr;
    logic [2:0]  eop;
    logic [31:0] edata;
  } vec_t;

  exp_t sbq[$];
  exp_t cur_exp;
  exp_t mon_e;
  vec_t vecs[$];
  int   compared;
  int   mismatched;

  tl_ul_dmem_device #(
    .DEPTH  (1024),
    .ADDR_W (12),
    .DATA_W (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .a_valid_i   (a_valid_i),
    .a_ready_o   (a_ready_o),
    .a_opcode_i  (a_opcode_i),
    .a_address_i (a_address_i),
    .a_data_i    (a_data_i),
    .a_size_i    (a_size_i),
    .a_mask_i    (a_mask_i),
    .d_valid_o   (d_valid_o),
    .d_ready_i   (d_ready_i),
    .d_opcode_o  (d_opcode_o),
    .d_size_o    (d_size_o),
    .d_data_o    (d_data_o),
    .d_error_o   (d_error_o)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic exp_t mkExp(input logic [2:0] op, input logic [1:0] size,
                                 input logic [31:0] data, input logic err);
    exp_t e;
    e.op = op; e.size = size; e.data = data; e.err = err;
    return e;
  endfunction

  // Scoreboard: pop on every D handshake, push on every A accept
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
    end else begin
      if (d_valid_o && d_ready_i) begin
        if (sbq.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_rsp: got response data 0x%08h with nothing outstanding", d_data_o);
        end else begin
          mon_e = sbq.pop_front();
          checkOutput("rsp {op,size,err,data}",
                      {26'd0, d_opcode_o, d_size_o, d_error_o, d_data_o},
                      {26'd0, mon_e.op, mon_e.size, mon_e.err, mon_e.data});
        end
      end
      if (a_valid_i && a_ready_o) sbq.push_back(cur_exp);
    end
  end

  // Called just after a rising edge; holds the request until accepted (bounded)
  task automatic applyStimulus(input logic [2:0] op, input logic [11:0] addr, input logic [1:0] size,
                               input logic [3:0] mask, input logic [31:0] data, input exp_t e);
    int waitCycles;
    cur_exp     = e;
    a_opcode_i  = op;
    a_address_i = addr;
    a_size_i    = size;
    a_mask_i    = mask;
    a_data_i    = data;
    a_valid_i   = 1'b1;
    waitCycles  = 0;
    @(negedge clk);
    while (!a_ready_o && waitCycles < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      waitCycles++;
    end
    if (!a_ready_o) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: a_ready_o=%0b after %0d cycles, required 1", a_ready_o, waitCycles);
    end
    @(posedge clk); #1;
    a_valid_i = 1'b0;
  endtask

  task automatic addVec(input logic [2:0] op, input logic [11:0] addr, input logic [1:0] size,
                        input logic [3:0] mask, input logic [31:0] data,
                        input logic eerr, input logic [2:0] eop, input logic [31:0] edata);
    vec_t v;
    v.op = op; v.addr = addr; v.size = size; v.mask = mask; v.data = data;
    v.eerr = eerr; v.eop = eop; v.edata = edata;
    vecs.push_back(v);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain_outstanding", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    rst         = 1'b1;
    a_valid_i   = 1'b0;
    a_opcode_i  = 3'd0;
    a_address_i = '0;
    a_data_i    = '0;
    a_size_i    = 2'd0;
    a_mask_i    = 4'd0;
    d_ready_i   = 1'b1;
    cur_exp     = mkExp(3'd0, 2'd0, 32'd0, 1'b0);

    // Vector table: op, addr, size, mask, data, expected err, opcode, data
    addVec(3'd0, 12'h010, 2'd2, 4'hF, 32'hDEADBEEF, 1'b0, 3'd0, 32'h0);
    addVec(3'd4, 12'h010, 2'd2, 4'hF, 32'h0,        1'b0, 3'd1, 32'hDEADBEEF);
    addVec(3'd1, 12'h012, 2'd1, 4'hC, 32'h12340000, 1'b0, 3'd0, 32'h0);
    addVec(3'd4, 12'h010, 2'd2, 4'hF, 32'h0,        1'b0, 3'd1, 32'h1234BEEF);
    addVec(3'd4, 12'h013, 2'd2, 4'hF, 32'h0,        1'b1, 3'd1, 32'h0);
    addVec(3'd3, 12'h010, 2'd2, 4'hF, 32'h55555555, 1'b1, 3'd0, 32'h0);
    addVec(3'd0, 12'h020, 2'd2, 4'hF, 32'hA5A5A5A5, 1'b0, 3'd0, 32'h0);
    addVec(3'd0, 12'h021, 2'd2, 4'hF, 32'h11111111, 1'b1, 3'd0, 32'h0);
    addVec(3'd4, 12'h020, 2'd2, 4'hF, 32'h0,        1'b0, 3'd1, 32'hA5A5A5A5);
    addVec(3'd4, 12'h011, 2'd0, 4'h2, 32'h0,        1'b0, 3'd1, 32'h0000BE00);
    addVec(3'd4, 12'h010, 2'd2, 4'h5, 32'h0,        1'b0, 3'd1, 32'h003400EF);
    addVec(3'd4, 12'h010, 2'd3, 4'hF, 32'h0,        1'b1, 3'd1, 32'h0);
    addVec(3'd1, 12'h010, 2'd0, 4'h2, 32'hFFFFFFFF, 1'b1, 3'd0, 32'h0);
    addVec(3'd0, 12'h010, 2'd1, 4'h1, 32'hFFFFFFFF, 1'b1, 3'd0, 32'h0);
    addVec(3'd4, 12'h010, 2'd2, 4'h0, 32'h0,        1'b1, 3'd1, 32'h0);
    addVec(3'd1, 12'h022, 2'd1, 4'h4, 32'h00770000, 1'b0, 3'd0, 32'h0);
    addVec(3'd4, 12'h020, 2'd2, 4'hF, 32'h0,        1'b0, 3'd1, 32'hA577A5A5);
    addVec(3'd4, 12'h021, 2'd1, 4'h3, 32'h0,        1'b1, 3'd1, 32'h0);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_d_valid", 64'(d_valid_o), 64'd0);
    checkOutput("reset_d_fields", {26'd0, d_opcode_o, d_size_o, d_error_o, d_data_o}, 64'd0);
    checkOutput("reset_a_ready", 64'(a_ready_o), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven pass at full throughput
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].size, vecs[i].mask, vecs[i].data,
                    mkExp(vecs[i].eop, vecs[i].size, vecs[i].edata, vecs[i].eerr));
    end
    drain();

    // Back-to-back: 8 puts then 8 gets, one per cycle
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'd0, 12'h040 + 12'(4*i), 2'd2, 4'hF, 32'hC0DE0000 + 32'(i),
                    mkExp(3'd0, 2'd2, 32'h0, 1'b0));
    end
    for (int i = 0; i < 8; i++) begin
      cur_exp     = mkExp(3'd1, 2'd2, 32'hC0DE0000 + 32'(i), 1'b0);
      a_opcode_i  = 3'd4;
      a_address_i = 12'h040 + 12'(4*i);
      a_size_i    = 2'd2;
      a_mask_i    = 4'hF;
      a_valid_i   = 1'b1;
      @(negedge clk);
      checkOutput("b2b_a_ready", 64'(a_ready_o), 64'd1);
      checkOutput("b2b_d_valid", 64'(d_valid_o), 64'd1);
      @(posedge clk); #1;
    end
    a_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("b2b_last_d_valid", 64'(d_valid_o), 64'd1);
    @(posedge clk); #1;
    drain();

    // Backpressure: response held, second request stalled for 3 cycles
    d_ready_i   = 1'b0;
    cur_exp     = mkExp(3'd1, 2'd2, 32'hA577A5A5, 1'b0);
    a_opcode_i  = 3'd4;
    a_address_i = 12'h020;
    a_size_i    = 2'd2;
    a_mask_i    = 4'hF;
    a_valid_i   = 1'b1;
    @(negedge clk);
    checkOutput("bp_first_accept", 64'(a_ready_o), 64'd1);
    @(posedge clk); #1;
    cur_exp     = mkExp(3'd1, 2'd2, 32'h1234BEEF, 1'b0);
    a_address_i = 12'h010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_a_ready", 64'(a_ready_o), 64'd0);
      checkOutput("bp_hold {valid,op,err,data}",
                  {27'd0, d_valid_o, d_opcode_o, d_error_o, d_data_o},
                  {27'd0, 1'b1, 3'd1, 1'b0, 32'hA577A5A5});
      @(posedge clk); #1;
    end
    d_ready_i = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_a_ready", 64'(a_ready_o), 64'd1);
    @(posedge clk); #1;
    a_valid_i = 1'b0;
    drain();
    @(posedge clk); #1;

    // Reset while a response is stalled
    d_ready_i   = 1'b0;
    cur_exp     = mkExp(3'd1, 2'd2, 32'h1234BEEF, 1'b0);
    a_opcode_i  = 3'd4;
    a_address_i = 12'h010;
    a_valid_i   = 1'b1;
    @(posedge clk); #1;
    a_valid_i = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    checkOutput("pre_reset_d_valid", 64'(d_valid_o), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_d_valid", 64'(d_valid_o), 64'd0);
    checkOutput("post_reset_a_ready", 64'(a_ready_o), 64'd1);
    @(posedge clk); #1;

    // A write presented during reset must be discarded
    d_ready_i   = 1'b1;
    rst         = 1'b1;
    a_opcode_i  = 3'd0;
    a_address_i = 12'h010;
    a_size_i    = 2'd2;
    a_mask_i    = 4'hF;
    a_data_i    = 32'hFFFFFFFF;
    a_valid_i   = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    a_valid_i = 1'b0;
    applyStimulus(3'd4, 12'h010, 2'd2, 4'hF, 32'h0, mkExp(3'd1, 2'd2, 32'h1234BEEF, 1'b0));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tl_ul_dmem_device.md
Name: tl_ul_dmem_device

Overview:
- TileLink-UL device (responder) end of the data-memory link, paired with the core's channel A host logic.
- Accepts channel A requests (Get, PutFullData, PutPartialData) into a word-organised synchronous memory.
- Returns one channel D response per accepted request, with valid/ready handshakes on both channels.
- One-entry registered response buffer, so back-to-back requests run at full throughput when d_ready_i stays high.

Parameters:
- DEPTH, 1024, number of 32-bit words; legal word index range 0..DEPTH-1.
- ADDR_W, 12, byte-address width of a_address_i.
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- a_valid_i  in  1  channel A request valid.
- a_ready_o  out  1  device can accept channel A this cycle.
- a_opcode_i  in  3  0=PutFullData, 1=PutPartialData, 4=Get; others illegal.
- a_address_i  in  ADDR_W  byte address.
- a_data_i  in  32  write data, byte lanes aligned to address.
- a_size_i  in  2  log2 bytes: 0=1B, 1=2B, 2=4B, 3=illegal.
- a_mask_i  in  4  byte-lane enables.
- d_valid_o  out  1  response valid.
- d_ready_i  in  1  host accepts response.
- d_opcode_o  out  3  0=AccessAck (puts), 1=AccessAckData (Get).
- d_size_o  out  2  echo of accepted a_size_i.
- d_data_o  out  32  read data; 0 for puts and errors.
- d_error_o  out  1  request rejected.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: d_valid_o=0, d_opcode_o=0, d_size_o=0, d_data_o=0, d_error_o=0, FSM=IDLE. Memory contents are not reset.
- a_ready_o = (state==IDLE) || d_ready_i. This is combinational; it must not depend on a_valid_i.
- Accept: a_valid_i && a_ready_o at a rising edge.
- FSM IDLE: on accept, go to RESP. Otherwise stay in IDLE.
- FSM RESP (d_valid_o=1):
  - d_ready_i && accept: stay in RESP and load the new response.
  - d_ready_i && !accept: go to IDLE.
  - !d_ready_i: hold all d_* outputs stable.
- Latency: the response is valid exactly 1 cycle after accept.
- Word index = a_address_i[ADDR_W-1:2].
- Error conditions (any one sets d_error_o=1, blocks the write, forces d_data_o=0):
  - Illegal opcode.
  - a_size_i==3.
  - Misalignment: size 1 with addr[0]!=0; size 2 with addr[1:0]!=0.
  - Index >= DEPTH.
  - Mask has lanes outside the addressed size/offset window.
  - PutFullData whose mask is not exactly that window (size 2 requires 4'hF).
  - Get with a_mask_i==0.
- d_opcode_o on error: still 1 for Get and 0 for puts and illegal opcodes.
- Writes: performed at the accept edge, byte-enabled by a_mask_i. Respond AccessAck with d_data_o=0.
- Reads: full word captured at the accept edge. Lanes with a_mask_i=0 return 0.
- Read-after-write: a Get accepted the cycle after a Put to the same word returns the new data. Same-edge conflicts are impossible because only one request is accepted per cycle.
- Backpressure: while d_ready_i=0 in RESP, a_ready_o=0 and no memory access occurs.
- Reset mid-operation: a pending response is dropped (d_valid_o=0 next cycle). A write accepted on the same edge as rst=1 is discarded.

Decomposition:
- Package tl_ul_pkg:
  - enum tl_a_op_e {PUT_FULL=3'd0, PUT_PARTIAL=3'd1, GET=3'd4}.
  - enum tl_d_op_e {ACK=3'd0, ACK_DATA=3'd1}.
  - Typedef tl_a_req_t and tl_d_rsp_t structs.
  - Function lane_window(size, addr[1:0]) returning the legal 4-bit lane mask.
- Sub-module tl_ul_req_check: combinational legality check. Outputs err and the lane window, and is reused by future TL-UL devices.
- Memory array inline; byte-enabled writes.

Test Plan:
- PutFullData addr 0x010, data 0xDEADBEEF, mask F, size 2 -> next cycle d_valid=1, d_opcode=0, d_error=0. Following Get 0x010 returns 0xDEADBEEF with d_opcode=1.
- PutPartialData addr 0x012, size 1, mask 4'b1100, data 0x12340000 over 0xDEADBEEF -> Get 0x010 returns 0x1234BEEF.
- Back-to-back 8 Gets with d_ready_i=1 -> a_ready_o stays 1, 8 responses on 8 consecutive cycles, correct order.
- Backpressure: Get accepted, d_ready_i=0 for 3 cycles -> d_* stable, a_ready_o=0, second request not accepted until d_ready_i=1.
- Errors:
  - Get addr 0x013 size 2 -> d_error=1, d_data=0.
  - Opcode 3 -> d_error=1, d_opcode=0.
  - Misaligned PutFull at 0x021 -> d_error=1, memory at 0x020 unchanged.
- rst=1 while d_valid_o=1 and d_ready_i=0 -> d_valid_o=0 next cycle, FSM IDLE, a_ready_o=1.
